// File: rtl/io_port_traffic_gen.sv
// Table-driven memory/IO port traffic source with write, read-check, write-then-read and interleaved modes.
// Define IOPG_TIMEOUT_EN to enable the ready watchdog; otherwise the block waits indefinitely for ready.
module io_port_traffic_gen #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 28,
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_W         = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [1:0]        mode,
  input  logic              loop_en,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] mem_data_wr,
  output logic [ADDR_W-1:0] mem_data_addr,
  output logic              mem_rw_data,
  output logic              mem_valid_data,
  input  logic              mem_ready_data,
  input  logic [DATA_W-1:0] mem_data_rd,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       err_count,
  output logic [IDX_W-1:0]  err_idx,
  output logic              timeout
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef IOPG_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] tbl_addr [DEPTH];
  logic [DATA_W-1:0] tbl_data [DEPTH];
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic              pass, pass_nxt;
  logic [1:0]        mode_q;
  logic              stop_seen;
  logic [GAP_W-1:0]  gap_cnt;
  logic [TMO_W-1:0]  tmo_cnt;

  logic start_ok, is_wr, accept, last_step, stop_any, tmo_hit, rd_mismatch;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // pass doubles as the write/read phase in mode 2 and the per-entry step in mode 3
  always_comb begin
    case (mode_q)
      2'd0:    is_wr = 1'b1;
      2'd1:    is_wr = 1'b0;
      default: is_wr = ~pass;
    endcase
  end

  assign start_ok    = start && (state == S_IDLE || state == S_DONE);
  assign accept      = (state == S_ISSUE) && mem_ready_data;
  assign last_step   = (idx == LAST_IDX) && (mode_q[1] ? pass : 1'b1);
  assign stop_any    = stop_seen | stop;
  assign tmo_hit     = TMO_EN && (state == S_ISSUE) && !mem_ready_data && (tmo_cnt == TMO_LAST);
  assign rd_mismatch = accept && !is_wr && (mem_data_rd != tbl_data[idx]);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    pass_nxt  = pass;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          state_nxt = S_ISSUE;
          idx_nxt   = '0;
          pass_nxt  = 1'b0;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          if (last_step) begin
            idx_nxt  = '0;
            pass_nxt = 1'b0;
          end else begin
            case (mode_q)
              2'd2: begin
                if (idx == LAST_IDX) begin
                  idx_nxt  = '0;
                  pass_nxt = 1'b1;
                end else begin
                  idx_nxt = idx + 1'b1;
                end
              end
              2'd3: begin
                pass_nxt = ~pass;
                if (pass) idx_nxt = idx + 1'b1;
              end
              default: idx_nxt = idx + 1'b1;
            endcase
          end
          if (stop_any || (last_step && !loop_en)) state_nxt = S_DONE;
          else if (GAP_CYCLES > 0)                 state_nxt = S_GAP;
          else                                     state_nxt = S_ISSUE;
        end else if (tmo_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_GAP: begin
        if (stop_any)                state_nxt = S_DONE;
        else if (gap_cnt == GAP_LAST) state_nxt = S_ISSUE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      pass      <= 1'b0;
      mode_q    <= 2'd0;
      stop_seen <= 1'b0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      error     <= 1'b0;
      err_count <= 16'd0;
      err_idx   <= '0;
      timeout   <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      pass    <= pass_nxt;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
      tmo_cnt <= (state == S_ISSUE && !mem_ready_data) ? tmo_cnt + 1'b1 : '0;
      if (start_ok) begin
        mode_q    <= mode;
        stop_seen <= 1'b0;
        error     <= 1'b0;
        err_count <= 16'd0;
        err_idx   <= '0;
        timeout   <= 1'b0;
      end else begin
        if (stop && (state == S_ISSUE || state == S_GAP)) stop_seen <= 1'b1;
        if (rd_mismatch) begin
          error     <= 1'b1;
          err_count <= sat_inc16(err_count);
          if (!error) err_idx <= idx;
        end
        if (tmo_hit) timeout <= 1'b1;
      end
    end
  end

  // Table contents survive reset; writes only land while no sequence is running
  always_ff @(posedge clk) begin
    if (cfg_we && !start && (state == S_IDLE || state == S_DONE)) begin
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  assign mem_valid_data = (state == S_ISSUE);
  assign mem_rw_data    = mem_valid_data && is_wr;
  assign mem_data_addr  = mem_valid_data ? tbl_addr[idx] : '0;
  assign mem_data_wr    = mem_rw_data ? tbl_data[idx] : '0;
  assign busy           = (state == S_ISSUE) || (state == S_GAP);
  assign done           = (state == S_DONE);

endmodule

// File: tb/tb_io_port_traffic_gen.sv
// Directed bench for io_port_traffic_gen: one instance with a 2-cycle gap, one back-to-back.
module tb_io_port_traffic_gen;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 28;
  localparam int DEPTH  = 4;
  localparam int IDX_W  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1;
  logic              cfg_we = 1'b0;
  logic [IDX_W-1:0]  cfg_idx = '0;
  logic [ADDR_W-1:0] cfg_addr = '0;
  logic [DATA_W-1:0] cfg_data = '0;
  logic [1:0]        mode = 2'd0;
  logic              loop_en = 1'b0;
  logic              start = 1'b0;
  logic              stop = 1'b0;

  logic [DATA_W-1:0] mem_data_wr, mem_data_rd;
  logic [ADDR_W-1:0] mem_data_addr;
  logic              mem_rw_data, mem_valid_data;
  logic              rdy = 1'b1;
  logic              busy, done, error, timeout;
  logic [15:0]       err_count;
  logic [IDX_W-1:0]  err_idx;

  logic [DATA_W-1:0] wr_b, rd_b;
  logic [ADDR_W-1:0] addr_b;
  logic              rw_b, valid_b, busy_b, done_b, error_b, timeout_b;
  logic              rdy_b = 1'b1;
  logic [15:0]       err_count_b;
  logic [IDX_W-1:0]  err_idx_b;

  io_port_traffic_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .GAP_CYCLES(2),
                        .TIMEOUT_CYCLES(8)) u_dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .mode(mode), .loop_en(loop_en), .start(start), .stop(stop),
    .mem_data_wr(mem_data_wr), .mem_data_addr(mem_data_addr), .mem_rw_data(mem_rw_data),
    .mem_valid_data(mem_valid_data), .mem_ready_data(rdy), .mem_data_rd(mem_data_rd),
    .busy(busy), .done(done), .error(error), .err_count(err_count), .err_idx(err_idx),
    .timeout(timeout));

  io_port_traffic_gen #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .GAP_CYCLES(0),
                        .TIMEOUT_CYCLES(8)) u_gap0 (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .mode(mode), .loop_en(loop_en), .start(start), .stop(stop),
    .mem_data_wr(wr_b), .mem_data_addr(addr_b), .mem_rw_data(rw_b),
    .mem_valid_data(valid_b), .mem_ready_data(rdy_b), .mem_data_rd(rd_b),
    .busy(busy_b), .done(done_b), .error(error_b), .err_count(err_count_b), .err_idx(err_idx_b),
    .timeout(timeout_b));

  // Loopback memory with optional corruption of one address
  logic [DATA_W-1:0] mem [16];
  logic              corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  assign rd_b = '0;

  always_comb begin
    mem_data_rd = '0;
    if (mem_valid_data && !mem_rw_data) begin
      if (corrupt_en && mem_data_addr == corrupt_addr) mem_data_rd = 32'hDEAD;
      else                                             mem_data_rd = mem[mem_data_addr[3:0]];
    end
  end

  int                cyc = 0;
  int                vcnt = 0, vcnt_b = 0;
  logic              q_rw[$];
  logic [ADDR_W-1:0] q_addr[$];
  logic [DATA_W-1:0] q_wd[$];
  int                q_cyc[$];
  logic [ADDR_W-1:0] q0_addr[$];
  int                q0_cyc[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_valid_data) vcnt <= vcnt + 1;
    if (valid_b) vcnt_b <= vcnt_b + 1;
    if (mem_valid_data && rdy) begin
      if (mem_rw_data) mem[mem_data_addr[3:0]] <= mem_data_wr;
      q_rw.push_back(mem_rw_data);
      q_addr.push_back(mem_data_addr);
      q_wd.push_back(mem_data_wr);
      q_cyc.push_back(cyc);
    end
    if (valid_b && rdy_b) begin
      q0_addr.push_back(addr_b);
      q0_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic load_table(input logic [DATA_W-1:0] dbase);
    for (int i = 0; i < DEPTH; i++) begin
      cfg_we   = 1'b1;
      cfg_idx  = IDX_W'(i);
      cfg_addr = 28'h8000004 + ADDR_W'(i);
      cfg_data = dbase + DATA_W'(i);
      @(negedge clk);
    end
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input logic [1:0] m, output int sc);
    mode  = m;
    start = 1'b1;
    sc    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s: done=%b after %0d cycles, required 1", name, done, budget);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({mem_valid_data, mem_rw_data, busy, done, error, timeout} !== 6'b0) begin
      failures++;
      $display("FAIL %s_flags: valid,rw,busy,done,error,timeout=%b required 000000", name,
               {mem_valid_data, mem_rw_data, busy, done, error, timeout});
    end
    checks++;
    if ({mem_data_wr, mem_data_addr, err_count, err_idx} !== '0) begin
      failures++;
      $display("FAIL %s_buses: wr=%h addr=%h err_count=%h err_idx=%h required all 0", name,
               mem_data_wr, mem_data_addr, err_count, err_idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_write_pass();
    int sc, b, v0;
    rdy = 1'b1;
    load_table(32'hA0);
    b = q_rw.size();
    v0 = vcnt;
    pulse_start(2'd0, sc);
    wait_done(60, "wp_done");
    checks++;
    if (q_rw.size() - b !== 4) begin
      failures++;
      $display("FAIL wp_count: commands=%0d required 4", q_rw.size() - b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if ({q_rw[b+i], q_addr[b+i], q_wd[b+i]} !== {1'b1, 28'h8000004 + ADDR_W'(i), 32'hA0 + DATA_W'(i)}
            || q_cyc[b+i] != sc + 1 + 3 * i) begin
          failures++;
          $display("FAIL wp_cmd%0d: rw=%b addr=%h data=%h cyc=%0d required rw=1 addr=%h data=%h cyc=%0d",
                   i, q_rw[b+i], q_addr[b+i], q_wd[b+i], q_cyc[b+i],
                   28'h8000004 + ADDR_W'(i), 32'hA0 + DATA_W'(i), sc + 1 + 3 * i);
        end
      end
    end
    checks++;
    if ({busy, mem_valid_data, mem_rw_data} !== 3'b000 || vcnt - v0 != 4) begin
      failures++;
      $display("FAIL wp_end: busy,valid,rw=%b valid_cycles=%0d required 000 and 4",
               {busy, mem_valid_data, mem_rw_data}, vcnt - v0);
    end
  endtask

  task automatic test_mode2();
    int sc, b;
    load_table(32'h1234_0000);
    b = q_rw.size();
    pulse_start(2'd2, sc);
    wait_done(100, "m2_done");
    checks++;
    if (q_rw.size() - b !== 8) begin
      failures++;
      $display("FAIL m2_count: commands=%0d required 8", q_rw.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if ({q_rw[b+i], q_addr[b+i]} !== {(i < 4) ? 1'b1 : 1'b0, 28'h8000004 + ADDR_W'(i % 4)}) begin
          failures++;
          $display("FAIL m2_cmd%0d: rw=%b addr=%h required rw=%b addr=%h", i, q_rw[b+i], q_addr[b+i],
                   (i < 4) ? 1'b1 : 1'b0, 28'h8000004 + ADDR_W'(i % 4));
        end
      end
    end
    checks++;
    if ({error, err_count} !== 17'd0) begin
      failures++;
      $display("FAIL m2_errors: error=%b err_count=%0d required 0/0", error, err_count);
    end
  endtask

  task automatic test_mode3_corrupt();
    int sc, b;
    corrupt_en   = 1'b1;
    corrupt_addr = 28'h8000006;
    b = q_rw.size();
    pulse_start(2'd3, sc);
    wait_done(100, "m3_done");
    checks++;
    if (q_rw.size() - b !== 8) begin
      failures++;
      $display("FAIL m3_count: commands=%0d required 8", q_rw.size() - b);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if ({q_rw[b+i], q_addr[b+i]} !== {(i % 2 == 0) ? 1'b1 : 1'b0, 28'h8000004 + ADDR_W'(i / 2)}) begin
          failures++;
          $display("FAIL m3_cmd%0d: rw=%b addr=%h required rw=%b addr=%h", i, q_rw[b+i], q_addr[b+i],
                   (i % 2 == 0) ? 1'b1 : 1'b0, 28'h8000004 + ADDR_W'(i / 2));
        end
      end
    end
    checks++;
    if ({error, err_count, err_idx} !== {1'b1, 16'd1, 2'd2}) begin
      failures++;
      $display("FAIL m3_errors: error=%b err_count=%0d err_idx=%0d required 1/1/2", error, err_count, err_idx);
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_stall();
    int sc, b, v0, n;
    rdy = 1'b1;
    b = q_rw.size();
    v0 = vcnt;
    pulse_start(2'd0, sc);
    n = 0;
    while (q_rw.size() < b + 1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    rdy = 1'b0;
    n = 0;
    while (!mem_valid_data && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if ({mem_valid_data, mem_rw_data, mem_data_addr, mem_data_wr} !== {2'b11, 28'h8000005, 32'h1234_0001}) begin
        failures++;
        $display("FAIL stall_hold%0d: valid=%b rw=%b addr=%h data=%h required 1 1 8000005 12340001",
                 k, mem_valid_data, mem_rw_data, mem_data_addr, mem_data_wr);
      end
      if (k < 5) @(negedge clk);
    end
    rdy = 1'b1;
    wait_done(60, "stall_done");
    checks++;
    if (q_rw.size() - b !== 4 || vcnt - v0 != 9) begin
      failures++;
      $display("FAIL stall_count: commands=%0d valid_cycles=%0d required 4 and 9", q_rw.size() - b, vcnt - v0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q_addr[b+i] !== 28'h8000004 + ADDR_W'(i)) begin
          failures++;
          $display("FAIL stall_order%0d: addr=%h required %h", i, q_addr[b+i], 28'h8000004 + ADDR_W'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int sc, b, v0;
    rdy = 1'b1;
    b = q0_cyc.size();
    v0 = vcnt_b;
    pulse_start(2'd0, sc);
    wait_done(60, "b2b_done");
    checks++;
    if (q0_cyc.size() - b !== 4 || vcnt_b - v0 != 4 || done_b !== 1'b1) begin
      failures++;
      $display("FAIL b2b_count: commands=%0d valid_cycles=%0d done=%b required 4, 4, 1",
               q0_cyc.size() - b, vcnt_b - v0, done_b);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (q0_cyc[b+i] != sc + 1 + i || q0_addr[b+i] !== 28'h8000004 + ADDR_W'(i)) begin
          failures++;
          $display("FAIL b2b_cmd%0d: cyc=%0d addr=%h required cyc=%0d addr=%h", i, q0_cyc[b+i], q0_addr[b+i],
                   sc + 1 + i, 28'h8000004 + ADDR_W'(i));
        end
      end
    end
  endtask

  task automatic test_loop_stop();
    int sc, b, n, s1, v1;
    rdy     = 1'b1;
    loop_en = 1'b1;
    b = q_rw.size();
    pulse_start(2'd0, sc);
    n = 0;
    while (q_rw.size() < b + 10 && n < 100) begin
      @(negedge clk);
      n++;
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    loop_en = 1'b0;
    checks++;
    if ({done, busy, mem_valid_data} !== 3'b100 || q_rw.size() - b != 10) begin
      failures++;
      $display("FAIL loop_stop: done,busy,valid=%b commands=%0d required 100 and 10",
               {done, busy, mem_valid_data}, q_rw.size() - b);
    end
    s1 = q_rw.size();
    v1 = vcnt;
    repeat (10) @(negedge clk);
    checks++;
    if (q_rw.size() != s1 || vcnt != v1) begin
      failures++;
      $display("FAIL loop_quiet: extra commands=%0d extra valid cycles=%0d required 0", q_rw.size() - s1, vcnt - v1);
    end
  endtask

  task automatic test_reset_mid();
    int sc;
    rdy = 1'b0;
    pulse_start(2'd0, sc);
    checks++;
    if ({mem_valid_data, busy} !== 2'b11) begin
      failures++;
      $display("FAIL rstmid_issue: valid,busy=%b required 11", {mem_valid_data, busy});
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rstmid");
    rst = 1'b0;
    rdy = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int sc;
    rdy = 1'b0;
    pulse_start(2'd0, sc);
`ifdef IOPG_TIMEOUT_EN
    repeat (7) @(negedge clk);
    checks++;
    if ({mem_valid_data, timeout, done} !== 3'b100) begin
      failures++;
      $display("FAIL tmo_before: valid,timeout,done=%b required 100", {mem_valid_data, timeout, done});
    end
    @(negedge clk);
    checks++;
    if ({mem_valid_data, timeout, done} !== 3'b011) begin
      failures++;
      $display("FAIL tmo_fire: valid,timeout,done=%b required 011", {mem_valid_data, timeout, done});
    end
`else
    repeat (20) @(negedge clk);
    checks++;
    if ({mem_valid_data, timeout, done} !== 3'b100) begin
      failures++;
      $display("FAIL tmo_off: valid,timeout,done=%b required 100", {mem_valid_data, timeout, done});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    rdy = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_pass();
    test_mode2();
    test_mode3_corrupt();
    test_stall();
    test_back_to_back();
    test_loop_stop();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/io_port_traffic_gen.md
Name: io_port_traffic_gen

Overview:
- Parametrised successor to the single-channel IO-port dummy driver.
- Drives the memory/IO port with a run-time-loadable table of (address, data) entries.
- Four sequencing modes, optional looping, a programmable inter-command gap, and full-width read-back checking with error counting and capture of the first failing entry.
- Sits between the top level and the memory/IO port arbiter as a bring-up and soak-test traffic source.

Parameters:
- DATA_W, 32, data bus width.
- ADDR_W, 28, address bus width.
- DEPTH, 16, number of table entries (2..256). IDX_W = $clog2(DEPTH).
- GAP_CYCLES, 16, idle cycles with valid low between commands. 0 means back-to-back commands.
- TIMEOUT_CYCLES, 1024, ready watchdog limit. Used only with IOPG_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  table write strobe.
- cfg_idx  in  IDX_W  table entry index.
- cfg_addr  in  ADDR_W  entry address.
- cfg_data  in  DATA_W  entry data, also the expected read value.
- mode  in  2  0=write pass, 1=read-check pass, 2=write pass then read pass, 3=interleaved write/readback per entry.
- loop_en  in  1  repeat the sequence until stop.
- start  in  1  single-cycle start pulse.
- stop  in  1  request to end after the current command.
- mem_data_wr  out  DATA_W  write data.
- mem_data_addr  out  ADDR_W  command address.
- mem_rw_data  out  1  1=write, 0=read.
- mem_valid_data  out  1  command valid.
- mem_ready_data  in  1  command accepted / read data valid.
- mem_data_rd  in  DATA_W  read data.
- busy  out  1  sequence in progress.
- done  out  1  sequence finished; held until start or rst.
- error  out  1  sticky mismatch flag.
- err_count  out  16  mismatch count; saturates at 16'hFFFF.
- err_idx  out  IDX_W  index of the first mismatch.
- timeout  out  1  watchdog fired (see Optional Feature).

Behaviour:
- Reset, outputs: rst (synchronous, active-high) forces IDLE. All outputs go to 0: mem_valid_data, mem_rw_data, mem_data_wr, mem_data_addr, busy, done, error, err_count, err_idx, timeout.
- Reset, table and mid-operation: table contents are not reset. rst asserted mid-command drops mem_valid_data on the next edge, with no completion.
- Table writes: cfg_we writes entry cfg_idx when the state is IDLE or DONE and start is low. Otherwise cfg_we is ignored.
- Start: start is accepted in IDLE or DONE and ignored while busy. On acceptance:
  - done is cleared.
  - error, err_count, err_idx and timeout are cleared.
  - idx and pass are set to 0.
  - The block enters ISSUE on the next cycle, so the first command appears 1 cycle after start.
- States: IDLE, ISSUE, GAP, DONE.
- ISSUE state:
  - mem_valid_data=1, with mem_data_addr=table[idx].addr.
  - mem_rw_data: 1 on a write step, 0 on a read step. mem_data_wr=table[idx].data on writes.
  - All command outputs are held stable until mem_valid_data & mem_ready_data.
- Acceptance edge: the step advances.
  - Modes 0 and 1: idx+1.
  - Mode 2: idx+1 within a pass. After idx=DEPTH-1 of the write pass, idx wraps to 0 and pass=read.
  - Mode 3: write step, then read step on the same idx, then idx+1.
- Read check: on a read acceptance, compare mem_data_rd against table[idx].data over the full DATA_W.
  - On mismatch: error<=1 and err_count<=err_count+1 (saturating).
  - err_idx is captured only when error was 0 before this mismatch.
- After acceptance:
  - If GAP_CYCLES>0: GAP state with mem_valid_data=0 for exactly GAP_CYCLES cycles, then ISSUE.
  - If GAP_CYCLES=0: the next command is presented on the next cycle with valid held high.
- End of sequence (last step accepted):
  - loop_en=1 and stop not seen: wrap to idx=0, pass=write, then follow the normal gap rule.
  - Otherwise: enter DONE with done=1, busy=0, mem_valid_data=0.
- stop:
  - Sampled any time in ISSUE or GAP and latched.
  - In ISSUE, the current command still completes; the next acceptance moves to DONE.
  - In GAP, the block moves to DONE immediately.
- busy=1 in ISSUE and GAP only.
- Default drive: mem_rw_data=0 whenever mem_valid_data=0.

Optional Feature:
- Macro: IOPG_TIMEOUT_EN.
- Defined:
  - A counter runs while in ISSUE with ready low.
  - When it reaches TIMEOUT_CYCLES: timeout<=1, mem_valid_data<=0, enter DONE (done=1).
  - The counter clears on every acceptance.
- Undefined: the block waits indefinitely for ready and timeout is tied to 0.

Test Plan:
- Write pass: DEPTH=4, mode=0, GAP_CYCLES=2, entries addr 28'h8000004+i / data 32'hA0+i, ready always 1 -> exactly 4 writes in index order, each valid pulse separated by 2 low cycles; done=1 and busy=0 after the 4th.
- Mode 2 with loopback memory model -> 4 writes then 4 reads; error=0 and err_count=0.
- Mode 3 with the model corrupting the read at idx 2 (returns 32'hDEAD) -> sequence W0 R0 W1 R1 W2 R2 W3 R3; error=1, err_count=1, err_idx=2.
- Ready stalled 5 cycles on the 2nd command -> addr/data/rw held stable for all 5 cycles; no skipped or duplicated command. GAP_CYCLES=0 -> back-to-back commands with valid never dropping.
- loop_en=1, stop pulsed mid-GAP of pass 3 -> DONE next cycle, no further valid. Then rst during ISSUE -> valid=0 the next cycle and all flags 0.
- IOPG_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, ready held 0 -> timeout=1 and done=1 exactly 8 cycles into the first ISSUE.
